// File: rtl/alu_op_sequencer_if.sv
// alu_op_sequencer_if: request, ALU, result and statistics signals of the ALU issue controller.
interface alu_op_sequencer_if #(parameter int WIDTH = 32, parameter int CNT_W = 8);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_aluop;
    logic [5:0]       in_funct;
    logic [WIDTH-1:0] in_A;
    logic [WIDTH-1:0] in_B;
    logic [WIDTH-1:0] A_in;
    logic [WIDTH-1:0] B_in;
    logic [3:0]       ALU_ctrl;
    logic [WIDTH-1:0] ALU_out;
    logic             zero;
    logic             overflow;
    logic             carry_out;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic [3:0]       out_flags;
    logic             clr_stats;
    logic [CNT_W-1:0] op_count;
    logic [CNT_W-1:0] ovf_count;
    modport slave (
        input  in_valid, in_aluop, in_funct, in_A, in_B, ALU_out, zero, overflow, carry_out,
               out_ready, clr_stats,
        output in_ready, A_in, B_in, ALU_ctrl, out_valid, out_result, out_flags, op_count, ovf_count
    );
    modport master (
        output in_valid, in_aluop, in_funct, in_A, in_B, ALU_out, zero, overflow, carry_out,
               out_ready, clr_stats,
        input  in_ready, A_in, B_in, ALU_ctrl, out_valid, out_result, out_flags, op_count, ovf_count
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: decodes MIPS-style ALU requests, drives a combinational ALU from registers,
// captures result/flags behind a valid/ready handshake and keeps saturating statistics.
module alu_op_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input logic             clk,
    input logic             rst,
    alu_op_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_e;
    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic [3:0]       ctrl_q, ctrl_d, flags_q, flags_d, dec_ctrl;
    logic             ill_q, ill_d, dec_ill;
    logic [CNT_W-1:0] op_q, op_d, ovf_q, ovf_d;
    always_comb begin
        dec_ill  = 1'b0;
        dec_ctrl = 4'b0010;
        case (bus.in_aluop)
            2'b01: dec_ctrl = 4'b0110;
            2'b11: dec_ctrl = 4'b1111;
            2'b10: case (bus.in_funct)
                6'b100000: dec_ctrl = 4'b0010;
                6'b100010: dec_ctrl = 4'b0110;
                6'b100100: dec_ctrl = 4'b0000;
                6'b100101: dec_ctrl = 4'b0001;
                6'b100111: dec_ctrl = 4'b1100;
                6'b101010: dec_ctrl = 4'b0111;
                default:   dec_ill  = 1'b1;
            endcase
            default: dec_ctrl = 4'b0010;
        endcase
    end
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        ctrl_d  = ctrl_q;
        ill_d   = ill_q;
        res_d   = res_q;
        flags_d = flags_q;
        op_d    = op_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: if (bus.in_valid) begin
                state_d = EXEC;
                a_d     = bus.in_A;
                b_d     = bus.in_B;
                ctrl_d  = dec_ctrl;
                ill_d   = dec_ill;
            end
            EXEC: begin
                state_d = DONE;
                res_d   = ill_q ? '0 : bus.ALU_out;
                flags_d = ill_q ? 4'b1001 : {1'b0, bus.carry_out, bus.overflow, bus.zero};
                op_d    = op_q + CNT_W'(!(&op_q));
                ovf_d   = ovf_q + CNT_W'(bus.overflow && !ill_q && !(&ovf_q));
            end
            DONE: state_d = bus.out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
        // a clear wins over the increment landing on the same edge
        if (bus.clr_stats) begin
            op_d  = '0;
            ovf_d = '0;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            ctrl_q  <= 4'b0010;
            ill_q   <= 1'b0;
            res_q   <= '0;
            flags_q <= '0;
            op_q    <= '0;
            ovf_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            ctrl_q  <= ctrl_d;
            ill_q   <= ill_d;
            res_q   <= res_d;
            flags_q <= flags_d;
            op_q    <= op_d;
            ovf_q   <= ovf_d;
        end
    end
    assign bus.in_ready   = state_q == IDLE;
    assign bus.out_valid  = state_q == DONE;
    assign bus.A_in       = a_q;
    assign bus.B_in       = b_q;
    assign bus.ALU_ctrl   = ctrl_q;
    assign bus.out_result = res_q;
    assign bus.out_flags  = flags_q;
    assign bus.op_count   = op_q;
    assign bus.ovf_count  = ovf_q;
endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Issue-side controller for the team's 32-bit combinational ALU.
- Accepts MIPS-style operation requests (ALUOp, funct, two operands) over a valid/ready handshake.
- Decodes each request to the 4-bit ALU control code, drives the ALU ports from registers, and captures result plus flags into an output register returned over a second valid/ready handshake.
- Keeps saturating operation and overflow statistics counters; sits between the decode stage and the ALU instance.

Parameters:
- WIDTH, 32, operand/result width; ALU instance width must match.
- CNT_W, 8, width of statistics counters.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept a request.
- in_aluop  input  2  00 add, 01 sub, 10 R-type (use funct), 11 equal compare.
- in_funct  input  6  R-type function field.
- in_A  input  WIDTH  operand A.
- in_B  input  WIDTH  operand B.
- A_in  output  WIDTH  registered operand A to ALU.
- B_in  output  WIDTH  registered operand B to ALU.
- ALU_ctrl  output  4  registered control code to ALU.
- ALU_out  input  WIDTH  ALU result.
- zero  input  1  ALU zero flag.
- overflow  input  1  ALU overflow flag.
- carry_out  input  1  ALU carry flag.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_result  output  WIDTH  captured result.
- out_flags  output  4  {illegal, carry, overflow, zero}.
- clr_stats  input  1  synchronous clear of both counters.
- op_count  output  CNT_W  completed operations, saturating.
- ovf_count  output  CNT_W  completed operations with overflow=1, saturating.

Behaviour:
- Reset (async, immediate):
  - State IDLE; in_ready=1, out_valid=0.
  - A_in=0, B_in=0, ALU_ctrl=4'b0010 (add).
  - out_result=0, out_flags=0, op_count=0, ovf_count=0.
- Decode, registered on accept:
  - aluop 00 -> 0010; aluop 01 -> 0110; aluop 11 -> 1111.
  - aluop 10 with funct 100000 -> 0010, 100010 -> 0110, 100100 -> 0000, 100101 -> 0001, 100111 -> 1100, 101010 -> 0111.
  - Any other funct under aluop 10 is illegal: ALU_ctrl=0010, illegal bit set.
- FSM IDLE -> EXEC -> DONE -> IDLE.
  - IDLE: in_ready=1. On in_valid=1 at edge N, latch in_A/in_B into A_in/B_in, latch the decoded code and illegal bit, go EXEC.
  - EXEC: in_ready=0 for exactly one cycle, during which the ALU settles combinationally. At edge N+1, capture ALU_out -> out_result and {illegal, carry_out, overflow, zero} -> out_flags, then go DONE.
  - Illegal op: capture out_result=0 and out_flags=4'b1001 (illegal, zero); ALU inputs ignored.
  - DONE: out_valid=1, first seen after edge N+1 (latency: accept edge to out_valid = 1 cycle, to consumable = 2). out_result and out_flags are held stable while out_valid=1 and out_ready=0.
  - DONE with out_ready=1 at an edge: go IDLE, out_valid=0. No new accept in that same cycle; throughput is one op per 3 cycles minimum.
- A_in, B_in and ALU_ctrl hold their last values outside EXEC (no toggling).
- Counters:
  - Update at the EXEC->DONE edge: op_count +1; ovf_count +1 if the captured overflow=1.
  - Both saturate at 2^CNT_W-1; illegal ops count in op_count only.
  - clr_stats=1 zeroes both at the next edge and takes priority over a simultaneous increment.
- Reset mid-operation (EXEC or DONE): pending op is discarded with no out_valid pulse, and counters are zeroed.
- in_valid while in_ready=0 is ignored; the requester must hold the request.

Test Plan:
- Reset, then aluop=10 funct=100000 A=0x7FFFFFFF B=0x00000001, out_ready=1 -> ALU_ctrl=0010 in EXEC; out_result=0x80000000, out_flags=0010; ovf_count=1, op_count=1.
- aluop=01 A=5 B=5 -> ALU_ctrl=0110, out_result=0, out_flags=0001; aluop=11 A=B=0x1234 -> out_result=1, zero flag=0.
- aluop=10 funct=101010 A=0xFFFFFFFF B=1 -> out_result=1; funct=100111 A=0 B=0 -> out_result=0xFFFFFFFF.
- aluop=10 funct=000011 -> out_flags=1001, out_result=0, op_count increments, ovf_count unchanged.
- Hold out_ready=0 for 5 cycles in DONE while toggling in_valid -> in_ready stays 0, out_result is stable, no second accept; out_ready=1 -> IDLE next cycle.
- Assert rst during EXEC -> out_valid never rises and all outputs return to reset values immediately. With CNT_W=2, run 5 overflowing adds -> counters hold at 3; then clr_stats plus an overflowing op in the same cycle -> both counters 0.
